// File: rtl/qr_pkg.sv
// ---------------------------------------------------------------------------
// qr_pkg
// Shared definitions for the QR row-processing blocks (row cleaner and
// run-length encoder).
//   QR_WIDTH  : default row length in pixels
//   QR_RUN_W  : default run-length / index width (2**QR_RUN_W > QR_WIDTH)
//   enc_state_e : state encoding of the run encoder FSM
// ---------------------------------------------------------------------------
package qr_pkg;

    localparam int QR_WIDTH = 480;
    localparam int QR_RUN_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2
    } enc_state_e;

endpackage : qr_pkg

// File: rtl/pattern_run_encoder.sv
// ---------------------------------------------------------------------------
// pattern_run_encoder
// Converts one cleaned pixel row into a stream of run-length tokens
// (color, length, last). One pixel is examined per clock in SCAN; each
// completed run is presented in EMIT with a valid/ready handshake.
//
// Ports
//   clk_in           : clock, rising edge
//   rst_in           : asynchronous active-low reset
//   data_valid_in    : one-cycle strobe, clean_pattern_in valid
//   clean_pattern_in : row pixels, bit 0 = leftmost, 1 = light
//   run_valid_out    : token valid
//   run_ready_in     : consumer accepts token
//   run_color_out    : pixel value of the run
//   run_length_out   : run length in pixels (1..WIDTH)
//   run_last_out     : token is the final run of the row
//   busy_out         : encoder is not idle
//   dropped_row_out  : one-cycle pulse when a row arrives while busy
// ---------------------------------------------------------------------------
module pattern_run_encoder
    import qr_pkg::*;
#(
    parameter int WIDTH = QR_WIDTH,
    parameter int RUN_W = QR_RUN_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             data_valid_in,
    input  logic [WIDTH-1:0] clean_pattern_in,
    output logic             run_valid_out,
    input  logic             run_ready_in,
    output logic             run_color_out,
    output logic [RUN_W-1:0] run_length_out,
    output logic             run_last_out,
    output logic             busy_out,
    output logic             dropped_row_out
);

    localparam logic [RUN_W-1:0] LAST_IDX = RUN_W'(WIDTH - 1);
    localparam logic [RUN_W-1:0] ONE      = RUN_W'(1);

    enc_state_e       state_q, state_d;
    logic [WIDTH-1:0] row_q, row_d;
    logic             color_q, color_d;
    logic [RUN_W-1:0] len_q, len_d;
    logic [RUN_W-1:0] index_q, index_d;
    logic             tok_color_q, tok_color_d;
    logic [RUN_W-1:0] tok_len_q, tok_len_d;
    logic             tok_last_q, tok_last_d;
    logic             final_pend_q, final_pend_d;
    logic             dropped_q, dropped_d;

    logic             cur_bit;
    logic             at_end;

    assign cur_bit = row_q[index_q];
    assign at_end  = (index_q == LAST_IDX);

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        color_d      = color_q;
        len_d        = len_q;
        index_d      = index_q;
        tok_color_d  = tok_color_q;
        tok_len_d    = tok_len_q;
        tok_last_d   = tok_last_q;
        final_pend_d = final_pend_q;
        dropped_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (data_valid_in) begin
                    row_d        = clean_pattern_in;
                    color_d      = clean_pattern_in[0];
                    len_d        = ONE;
                    index_d      = ONE;
                    final_pend_d = 1'b0;
                    state_d      = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (cur_bit == color_q) begin
                    len_d = len_q + ONE;
                    if (at_end) begin
                        tok_color_d = color_q;
                        tok_len_d   = len_q + ONE;
                        tok_last_d  = 1'b1;
                        state_d     = ST_EMIT;
                    end else begin
                        index_d = index_q + ONE;
                    end
                end else begin
                    // Close the current run; the new one starts at this pixel.
                    tok_color_d  = color_q;
                    tok_len_d    = len_q;
                    tok_last_d   = 1'b0;
                    color_d      = cur_bit;
                    len_d        = ONE;
                    // A color change on the final pixel leaves a 1-pixel run
                    // that must follow as the last token.
                    final_pend_d = at_end;
                    state_d      = ST_EMIT;
                end
            end

            ST_EMIT: begin
                if (run_ready_in) begin
                    if (tok_last_q) begin
                        state_d = ST_IDLE;
                    end else if (final_pend_q) begin
                        tok_color_d  = color_q;
                        tok_len_d    = ONE;
                        tok_last_d   = 1'b1;
                        final_pend_d = 1'b0;
                    end else begin
                        index_d = index_q + ONE;
                        state_d = ST_SCAN;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Rows arriving mid-encode are discarded and flagged.
        if (data_valid_in && (state_q != ST_IDLE)) begin
            dropped_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            color_q      <= 1'b0;
            len_q        <= '0;
            index_q      <= '0;
            tok_color_q  <= 1'b0;
            tok_len_q    <= '0;
            tok_last_q   <= 1'b0;
            final_pend_q <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            color_q      <= color_d;
            len_q        <= len_d;
            index_q      <= index_d;
            tok_color_q  <= tok_color_d;
            tok_len_q    <= tok_len_d;
            tok_last_q   <= tok_last_d;
            final_pend_q <= final_pend_d;
            dropped_q    <= dropped_d;
        end
    end

    assign run_valid_out   = (state_q == ST_EMIT);
    assign run_color_out   = tok_color_q;
    assign run_length_out  = tok_len_q;
    assign run_last_out    = tok_last_q;
    assign busy_out        = (state_q != ST_IDLE);
    assign dropped_row_out = dropped_q;

endmodule : pattern_run_encoder

// File: tb/tb_pattern_run_encoder.sv
// ---------------------------------------------------------------------------
// tb_pattern_run_encoder
// Directed tests for pattern_run_encoder at its default size (480 pixels).
// Stimulus is driven and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_pattern_run_encoder;

    localparam int WIDTH = 480;
    localparam int RUN_W = 9;

    logic             clk_in;
    logic             rst_in;
    logic             data_valid_in;
    logic [WIDTH-1:0] clean_pattern_in;
    logic             run_valid_out;
    logic             run_ready_in;
    logic             run_color_out;
    logic [RUN_W-1:0] run_length_out;
    logic             run_last_out;
    logic             busy_out;
    logic             dropped_row_out;

    int checks;
    int errors;

    // Collected token stream for the row under test.
    int   tok_n;
    logic tok_color [0:599];
    int   tok_len   [0:599];
    logic tok_last  [0:599];
    int   first_edge;
    int   done_edge;

    pattern_run_encoder #(
        .WIDTH (WIDTH),
        .RUN_W (RUN_W)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .data_valid_in    (data_valid_in),
        .clean_pattern_in (clean_pattern_in),
        .run_valid_out    (run_valid_out),
        .run_ready_in     (run_ready_in),
        .run_color_out    (run_color_out),
        .run_length_out   (run_length_out),
        .run_last_out     (run_last_out),
        .busy_out         (busy_out),
        .dropped_row_out  (dropped_row_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Present a row for exactly one rising edge; returns on the falling
    // edge right after the sampling edge.
    task automatic send_row(input logic [WIDTH-1:0] p);
        @(negedge clk_in);
        clean_pattern_in = p;
        data_valid_in    = 1'b1;
        @(negedge clk_in);
        data_valid_in    = 1'b0;
    endtask

    // Gather tokens until the last one is accepted or the budget expires.
    // Edge numbering counts the data_valid sampling edge as edge 1.
    task automatic collect(input int budget);
        bit done;
        done       = 1'b0;
        tok_n      = 0;
        first_edge = -1;
        done_edge  = -1;
        for (int e = 1; e <= budget && !done; e++) begin
            if (run_valid_out && first_edge < 0) first_edge = e;
            if (run_valid_out && run_ready_in && tok_n < 600) begin
                tok_color[tok_n] = run_color_out;
                tok_len[tok_n]   = int'(run_length_out);
                tok_last[tok_n]  = run_last_out;
                tok_n++;
                if (run_last_out) begin
                    done_edge = e + 1;
                    done      = 1'b1;
                end
            end
            @(negedge clk_in);
        end
    endtask

    task automatic test_reset;
        rst_in           = 1'b0;
        run_ready_in     = 1'b1;
        data_valid_in    = 1'b0;
        clean_pattern_in = '0;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({run_valid_out, run_last_out, busy_out, dropped_row_out} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {run_valid_out, run_last_out, busy_out, dropped_row_out});
        end
        checks++;
        if (run_length_out !== '0 || run_color_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_token: got len=%0d color=%b expected 0/0",
                     run_length_out, run_color_out);
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        $display("reset: released");
    endtask

    task automatic test_all_ones;
        logic [WIDTH-1:0] p;
        p = '1;
        send_row(p);
        collect(600);
        checks++;
        if (tok_n !== 1) begin
            errors++;
            $display("FAIL ones_count: got %0d expected 1", tok_n);
        end else begin
            checks++;
            if (tok_color[0] !== 1'b1 || tok_len[0] !== WIDTH || tok_last[0] !== 1'b1) begin
                errors++;
                $display("FAIL ones_token: got (%b,%0d,%b) expected (1,480,1)",
                         tok_color[0], tok_len[0], tok_last[0]);
            end
        end
        checks++;
        if (first_edge !== WIDTH) begin
            errors++;
            $display("FAIL ones_latency: got %0d expected %0d", first_edge, WIDTH);
        end
        checks++;
        if (busy_out !== 1'b0) begin
            errors++;
            $display("FAIL ones_idle: busy got %b expected 0", busy_out);
        end
        $display("all_ones: tokens=%0d first_valid_edge=%0d", tok_n, first_edge);
    endtask

    task automatic test_alternating;
        logic [WIDTH-1:0] p;
        int bad;
        for (int i = 0; i < WIDTH; i++) p[i] = ((i / 6) % 2) != 0;
        send_row(p);
        collect(700);
        checks++;
        if (tok_n !== 80) begin
            errors++;
            $display("FAIL alt_count: got %0d expected 80", tok_n);
        end
        bad = 0;
        for (int j = 0; j < tok_n && j < 80; j++) begin
            checks++;
            if (tok_len[j] !== 6 || tok_color[j] !== logic'(j % 2) || tok_last[j] !== (j == 79)) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL alt_token[%0d]: got (%b,%0d,%b) expected (%0d,6,%0d)",
                             j, tok_color[j], tok_len[j], tok_last[j], j % 2, j == 79);
            end
        end
        checks++;
        if (done_edge < WIDTH + 80 - 1 || done_edge > WIDTH + 80 + 1) begin
            errors++;
            $display("FAIL alt_duration: got %0d expected %0d +-1", done_edge, WIDTH + 80);
        end
        $display("alternating: tokens=%0d done_edge=%0d", tok_n, done_edge);
    endtask

    task automatic test_edge_pixels;
        logic [WIDTH-1:0] p;
        p    = '1;
        p[0] = 1'b0;
        send_row(p);
        collect(600);
        checks++;
        if (tok_n !== 2 || tok_color[0] !== 1'b0 || tok_len[0] !== 1 || tok_last[0] !== 1'b0
            || tok_color[1] !== 1'b1 || tok_len[1] !== 479 || tok_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL first_pixel: got n=%0d (%b,%0d,%b) (%b,%0d,%b) expected (0,1,0) (1,479,1)",
                     tok_n, tok_color[0], tok_len[0], tok_last[0],
                     tok_color[1], tok_len[1], tok_last[1]);
        end
        $display("first_pixel_dark: tokens=%0d", tok_n);

        p          = '1;
        p[WIDTH-1] = 1'b0;
        send_row(p);
        collect(600);
        checks++;
        if (tok_n !== 2 || tok_color[0] !== 1'b1 || tok_len[0] !== 479 || tok_last[0] !== 1'b0
            || tok_color[1] !== 1'b0 || tok_len[1] !== 1 || tok_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL last_pixel: got n=%0d (%b,%0d,%b) (%b,%0d,%b) expected (1,479,0) (0,1,1)",
                     tok_n, tok_color[0], tok_len[0], tok_last[0],
                     tok_color[1], tok_len[1], tok_last[1]);
        end
        $display("last_pixel_dark: tokens=%0d", tok_n);
    endtask

    task automatic test_backpressure;
        logic [WIDTH-1:0] p;
        logic             s_color;
        logic [RUN_W-1:0] s_len;
        logic             s_last;
        int               wait_cnt;
        int               sum;
        bit               alt_ok;
        for (int i = 0; i < WIDTH; i++) p[i] = ((i / 6) % 2) != 0;
        run_ready_in = 1'b0;
        send_row(p);
        wait_cnt = 0;
        while (!run_valid_out && wait_cnt < 50) begin
            @(negedge clk_in);
            wait_cnt++;
        end
        checks++;
        if (run_valid_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_first_valid: got %b expected 1 within 50 cycles", run_valid_out);
        end
        s_color = run_color_out;
        s_len   = run_length_out;
        s_last  = run_last_out;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_in);
            checks++;
            if (run_valid_out !== 1'b1 || run_color_out !== s_color
                || run_length_out !== s_len || run_last_out !== s_last) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got (%b,%b,%0d,%b) expected (1,%b,%0d,%b)",
                         c, run_valid_out, run_color_out, run_length_out, run_last_out,
                         s_color, s_len, s_last);
            end
        end
        run_ready_in = 1'b1;
        collect(700);
        sum    = 0;
        alt_ok = 1'b1;
        for (int j = 0; j < tok_n; j++) begin
            sum += tok_len[j];
            if (j > 0 && tok_color[j] === tok_color[j-1]) alt_ok = 1'b0;
        end
        checks++;
        if (tok_n !== 80 || sum !== WIDTH || !alt_ok || tok_color[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_stream: got n=%0d sum=%0d alt=%0d first_color=%b expected 80/480/1/0",
                     tok_n, sum, alt_ok, tok_color[0]);
        end
        $display("backpressure: tokens=%0d sum=%0d", tok_n, sum);
    endtask

    task automatic test_drop;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] z;
        int               pulses;
        p          = '1;
        p[WIDTH-1] = 1'b0;
        z          = '0;
        send_row(p);
        repeat (3) @(negedge clk_in);
        clean_pattern_in = z;
        data_valid_in    = 1'b1;
        @(negedge clk_in);
        data_valid_in = 1'b0;
        checks++;
        if (dropped_row_out !== 1'b1) begin
            errors++;
            $display("FAIL drop_pulse: got %b expected 1", dropped_row_out);
        end
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            if (dropped_row_out === 1'b1) pulses++;
            @(negedge clk_in);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL drop_width: got %0d cycles expected 1", pulses);
        end
        collect(600);
        checks++;
        if (tok_n !== 2 || tok_color[0] !== 1'b1 || tok_len[0] !== 479 || tok_last[0] !== 1'b0
            || tok_color[1] !== 1'b0 || tok_len[1] !== 1 || tok_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL drop_stream: got n=%0d (%b,%0d,%b) (%b,%0d,%b) expected (1,479,0) (0,1,1)",
                     tok_n, tok_color[0], tok_len[0], tok_last[0],
                     tok_color[1], tok_len[1], tok_last[1]);
        end
        $display("drop: pulses=%0d tokens=%0d", pulses, tok_n);
    endtask

    task automatic test_reset_mid_row;
        logic [WIDTH-1:0] p;
        int               stray;
        p = '1;
        send_row(p);
        repeat (199) @(negedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        checks++;
        if ({run_valid_out, run_last_out, busy_out, dropped_row_out, run_color_out} !== 5'b00000
            || run_length_out !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got v=%b l=%b b=%b d=%b c=%b len=%0d expected all 0",
                     run_valid_out, run_last_out, busy_out, dropped_row_out,
                     run_color_out, run_length_out);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        stray  = 0;
        for (int c = 0; c < 600; c++) begin
            if (run_valid_out || busy_out) stray++;
            @(negedge clk_in);
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d active cycles expected 0", stray);
        end
        p    = '1;
        p[0] = 1'b0;
        send_row(p);
        collect(600);
        checks++;
        if (tok_n !== 2 || tok_color[0] !== 1'b0 || tok_len[0] !== 1 || tok_last[0] !== 1'b0
            || tok_color[1] !== 1'b1 || tok_len[1] !== 479 || tok_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_next_row: got n=%0d (%b,%0d,%b) (%b,%0d,%b) expected (0,1,0) (1,479,1)",
                     tok_n, tok_color[0], tok_len[0], tok_last[0],
                     tok_color[1], tok_len[1], tok_last[1]);
        end
        $display("reset_mid_row: stray=%0d next_row_tokens=%0d", stray, tok_n);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_all_ones();
        test_alternating();
        test_edge_pixels();
        test_backpressure();
        test_drop();
        test_reset_mid_row();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pattern_run_encoder
